// File: rtl/life_gen_scheduler.sv
// life_gen_scheduler
//   Runs one Game of Life generation over a double-buffered, single-port
//   board RAM (one word per row) and shares that RAM with the host loader.
//   The sweep reads the source bank (disp_bank) row by row, keeps a
//   three-row window (north/mid/south), presents it to an external
//   combinational rule block, and writes the result row into the opposite
//   bank. It counts completed generations and raises sticky win/lose flags.
//
// Ports
//   clka                   rising-edge clock
//   reset                  asynchronous active-low reset
//   restart                synchronous game clear, back to IDLE (bank kept)
//   step / auto            one-shot / continuous generation request
//   load_req/addr/data     host row write request (held until load_ack)
//   load_ack               one-cycle pulse in the cycle the host write occurs
//   mem_en/we/bank/addr/wdata, mem_rdata
//                          single-port RAM; read data arrives one cycle later
//   rule_north/mid/south   window rows r-1, r, r+1 to the rule block
//   rule_next              rule block result for row r
//   busy                   generation in progress
//   disp_bank              bank holding the current generation
//   gen_count              completed generations (wraps)
//   win / lose             sticky end-of-game flags
module life_gen_scheduler #(
  parameter int ROWS    = 8,
  parameter int COLS    = 8,
  parameter int AW      = 3,
  parameter int GEN_W   = 9,
  parameter int WIN_GEN = 50
) (
  input  logic             clka,
  input  logic             reset,
  input  logic             restart,
  input  logic             step,
  input  logic             auto,
  input  logic             load_req,
  input  logic [AW-1:0]    load_addr,
  input  logic [COLS-1:0]  load_data,
  output logic             load_ack,
  output logic             mem_en,
  output logic             mem_we,
  output logic             mem_bank,
  output logic [AW-1:0]    mem_addr,
  output logic [COLS-1:0]  mem_wdata,
  input  logic [COLS-1:0]  mem_rdata,
  output logic [COLS-1:0]  rule_north,
  output logic [COLS-1:0]  rule_mid,
  output logic [COLS-1:0]  rule_south,
  input  logic [COLS-1:0]  rule_next,
  output logic             busy,
  output logic             disp_bank,
  output logic [GEN_W-1:0] gen_count,
  output logic             win,
  output logic             lose
);

  typedef enum logic [3:0] {
    S_IDLE,
    S_LOAD,
    S_FILL_RD,
    S_FILL_CAP,
    S_ROW_RD,
    S_ROW_WR,
    S_CHECK,
    S_WIN,
    S_LOSE
  } state_t;

  localparam logic [AW-1:0]    LAST_ROW = AW'(ROWS - 1);
  localparam logic [GEN_W-1:0] WIN_CNT  = GEN_W'(WIN_GEN);

  state_t           state_q;
  logic [AW-1:0]    row_q;
  logic [COLS-1:0]  north_q, mid_q;          // sliding window (rows r-1, r)
  logic [COLS-1:0]  hold_n_q, hold_m_q, hold_s_q; // last window shown to rules
  logic             alive_q;
  logic             step_pend_q;
  logic             busy_q;
  logic             ack_q;
  logic             disp_q;
  logic [GEN_W-1:0] gen_q;
  logic             win_q;
  logic             lose_q;

  logic             last_row;
  logic [COLS-1:0]  south_in;
  logic [GEN_W-1:0] gen_inc;

  assign last_row = (row_q == LAST_ROW);
  // Below the last row the board has a dead border; there is no read pending.
  assign south_in = last_row ? '0 : mem_rdata;
  assign gen_inc  = gen_q + 1'b1;

  // RAM port and rule window decode. In ROW_WR the window is live (the south
  // row comes straight from RAM read data); elsewhere the last window holds.
  always_comb begin
    mem_en     = 1'b0;
    mem_we     = 1'b0;
    mem_bank   = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
    rule_north = hold_n_q;
    rule_mid   = hold_m_q;
    rule_south = hold_s_q;
    case (state_q)
      S_LOAD: begin
        mem_en    = 1'b1;
        mem_we    = 1'b1;
        mem_bank  = disp_q;
        mem_addr  = load_addr;
        mem_wdata = load_data;
      end
      S_FILL_RD: begin
        mem_en   = 1'b1;
        mem_bank = disp_q;
        mem_addr = '0;
      end
      S_ROW_RD: begin
        if (!last_row) begin
          mem_en   = 1'b1;
          mem_bank = disp_q;
          mem_addr = row_q + 1'b1;
        end
      end
      S_ROW_WR: begin
        mem_en     = 1'b1;
        mem_we     = 1'b1;
        mem_bank   = ~disp_q;
        mem_addr   = row_q;
        mem_wdata  = rule_next;
        rule_north = north_q;
        rule_mid   = mid_q;
        rule_south = south_in;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clka or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      row_q       <= '0;
      north_q     <= '0;
      mid_q       <= '0;
      hold_n_q    <= '0;
      hold_m_q    <= '0;
      hold_s_q    <= '0;
      alive_q     <= 1'b0;
      step_pend_q <= 1'b0;
      busy_q      <= 1'b0;
      ack_q       <= 1'b0;
      disp_q      <= 1'b0;
      gen_q       <= '0;
      win_q       <= 1'b0;
      lose_q      <= 1'b0;
    end else begin
      ack_q <= 1'b0;
      // Later assignments below (restart, FILL_RD entry) override this set.
      if (step && state_q != S_WIN && state_q != S_LOSE) begin
        step_pend_q <= 1'b1;
      end

      if (restart) begin
        state_q     <= S_IDLE;
        gen_q       <= '0;
        win_q       <= 1'b0;
        lose_q      <= 1'b0;
        step_pend_q <= 1'b0;
        busy_q      <= 1'b0;
        // A completed sweep still commits its bank swap.
        if (state_q == S_CHECK) begin
          disp_q <= ~disp_q;
        end
      end else begin
        case (state_q)
          S_IDLE: begin
            if (load_req) begin
              state_q <= S_LOAD;
              ack_q   <= 1'b1;
            end else if (step_pend_q || auto) begin
              state_q     <= S_FILL_RD;
              busy_q      <= 1'b1;
              step_pend_q <= 1'b0;
            end
          end
          S_LOAD:    state_q <= S_IDLE;
          S_FILL_RD: state_q <= S_FILL_CAP;
          S_FILL_CAP: begin
            north_q <= '0;
            mid_q   <= mem_rdata;
            row_q   <= '0;
            alive_q <= 1'b0;
            state_q <= S_ROW_RD;
          end
          S_ROW_RD:  state_q <= S_ROW_WR;
          S_ROW_WR: begin
            hold_n_q <= north_q;
            hold_m_q <= mid_q;
            hold_s_q <= south_in;
            alive_q  <= alive_q | (|rule_next);
            north_q  <= mid_q;
            mid_q    <= south_in;
            if (last_row) begin
              state_q <= S_CHECK;
            end else begin
              row_q   <= row_q + 1'b1;
              state_q <= S_ROW_RD;
            end
          end
          S_CHECK: begin
            disp_q <= ~disp_q;
            gen_q  <= gen_inc;
            busy_q <= 1'b0;
            if (!alive_q) begin
              lose_q  <= 1'b1;
              state_q <= S_LOSE;
            end else if (gen_inc >= WIN_CNT) begin
              win_q   <= 1'b1;
              state_q <= S_WIN;
            end else begin
              state_q <= S_IDLE;
            end
          end
          S_WIN:   state_q <= S_WIN;
          S_LOSE:  state_q <= S_LOSE;
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

  assign load_ack  = ack_q;
  assign busy      = busy_q;
  assign disp_bank = disp_q;
  assign gen_count = gen_q;
  assign win       = win_q;
  assign lose      = lose_q;

endmodule

// File: tb/tb_life_gen_scheduler.sv
// Bench for life_gen_scheduler: provides a behavioural board RAM and rule
// block, and checks results against a whole-board Game of Life model.
`define CHK(tag, obs, exp) \
  begin \
    checks++; \
    assert ((obs) === (exp)) else begin \
      errors++; \
      $error("FAIL %s observed=%0h expected=%0h", tag, (obs), (exp)); \
    end \
  end

module tb_life_gen_scheduler;
  localparam int ROWS    = 8;
  localparam int COLS    = 8;
  localparam int AW      = 3;
  localparam int GEN_W   = 9;
  localparam int WIN_GEN = 3;

  logic             clka = 1'b0;
  logic             reset, restart, step, auto, load_req;
  logic [AW-1:0]    load_addr;
  logic [COLS-1:0]  load_data;
  logic             load_ack, mem_en, mem_we, mem_bank;
  logic [AW-1:0]    mem_addr;
  logic [COLS-1:0]  mem_wdata, mem_rdata;
  logic [COLS-1:0]  rule_north, rule_mid, rule_south, rule_next;
  logic             busy, disp_bank, win, lose;
  logic [GEN_W-1:0] gen_count;

  int checks = 0;
  int errors = 0;

  always #5 clka = ~clka;

  life_gen_scheduler #(
    .ROWS(ROWS), .COLS(COLS), .AW(AW), .GEN_W(GEN_W), .WIN_GEN(WIN_GEN)
  ) dut (
    .clka(clka), .reset(reset), .restart(restart), .step(step), .auto(auto),
    .load_req(load_req), .load_addr(load_addr), .load_data(load_data),
    .load_ack(load_ack), .mem_en(mem_en), .mem_we(mem_we),
    .mem_bank(mem_bank), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .rule_north(rule_north), .rule_mid(rule_mid),
    .rule_south(rule_south), .rule_next(rule_next), .busy(busy),
    .disp_bank(disp_bank), .gen_count(gen_count), .win(win), .lose(lose)
  );

  // Board RAM: synchronous write, registered read data.
  logic [COLS-1:0] ram [2][ROWS];
  logic [COLS-1:0] rdata_q;
  always @(posedge clka) begin
    if (mem_en) begin
      if (mem_we) ram[mem_bank][mem_addr] <= mem_wdata;
      else        rdata_q <= ram[mem_bank][mem_addr];
    end
  end
  assign mem_rdata = rdata_q;

  // Rule block: next state of the middle row of a three-row strip.
  function automatic logic [COLS-1:0] rule_fn(input logic [COLS-1:0] n,
                                               input logic [COLS-1:0] m,
                                               input logic [COLS-1:0] s);
    logic [COLS-1:0] rows [3];
    logic [COLS-1:0] res;
    int cnt;
    rows[0] = n; rows[1] = m; rows[2] = s;
    res = '0;
    for (int c = 0; c < COLS; c++) begin
      cnt = 0;
      for (int dr = 0; dr < 3; dr++)
        for (int dc = -1; dc <= 1; dc++)
          if (!(dr == 1 && dc == 0) && c + dc >= 0 && c + dc < COLS)
            cnt += int'(rows[dr][c+dc]);
      res[c] = (cnt == 3) || (m[c] && cnt == 2);
    end
    return res;
  endfunction
  assign rule_next = rule_fn(rule_north, rule_mid, rule_south);

  // Reference model: whole board state and game bookkeeping.
  logic [COLS-1:0] exp_mem [2][ROWS];
  logic            exp_disp;
  int              exp_gen;
  logic            exp_win, exp_lose;

  function automatic int cellv(input logic b, input int r, input int c);
    if (r < 0 || r >= ROWS || c < 0 || c >= COLS) return 0;
    return int'(exp_mem[b][r][c]);
  endfunction

  function automatic logic [COLS-1:0] next_row(input logic b, input int r);
    logic [COLS-1:0] res;
    int n;
    res = '0;
    for (int c = 0; c < COLS; c++) begin
      n = 0;
      for (int dr = -1; dr <= 1; dr++)
        for (int dc = -1; dc <= 1; dc++)
          if (dr != 0 || dc != 0) n += cellv(b, r + dr, c + dc);
      res[c] = (n == 3) || (cellv(b, r, c) == 1 && n == 2);
    end
    return res;
  endfunction

  task automatic model_gen();
    logic [COLS-1:0] tmp [ROWS];
    bit alive;
    alive = 0;
    for (int r = 0; r < ROWS; r++) begin
      tmp[r] = next_row(exp_disp, r);
      if (tmp[r] != '0) alive = 1;
    end
    for (int r = 0; r < ROWS; r++) exp_mem[!exp_disp][r] = tmp[r];
    exp_disp = !exp_disp;
    exp_gen++;
    if (!alive) exp_lose = 1'b1;
    else if (exp_gen >= WIN_GEN) exp_win = 1'b1;
  endtask

  task automatic tick();
    @(posedge clka);
    #1;
  endtask

  task automatic chk_bank(input string tag, input logic b);
    for (int r = 0; r < ROWS; r++)
      `CHK($sformatf("%s_r%0d", tag, r), ram[b][r], exp_mem[b][r])
  endtask

  task automatic chk_flags(input string tag);
    `CHK({tag, "_disp"}, disp_bank, exp_disp)
    `CHK({tag, "_gen"}, gen_count, GEN_W'(exp_gen))
    `CHK({tag, "_win"}, win, exp_win)
    `CHK({tag, "_lose"}, lose, exp_lose)
  endtask

  task automatic chk_all_zero(input string tag);
    `CHK(tag, {load_ack, mem_en, mem_we, mem_bank, mem_addr, mem_wdata,
               rule_north, rule_mid, rule_south, busy, disp_bank, gen_count,
               win, lose}, 52'h0)
  endtask

  task automatic do_load(input logic [AW-1:0] a, input logic [COLS-1:0] d);
    bit got;
    got = 0;
    load_req = 1'b1; load_addr = a; load_data = d;
    for (int i = 0; i < 60 && !got; i++) begin
      tick();
      if (load_ack) got = 1;
    end
    `CHK("load_ack_seen", got, 1'b1)
    load_req = 1'b0;
    tick();
    `CHK("load_ack_pulse", load_ack, 1'b0)
    if (got) exp_mem[exp_disp][a] = d;
  endtask

  task automatic load_random();
    for (int r = 0; r < ROWS; r++)
      do_load(AW'(r), COLS'($urandom & $urandom));
  endtask

  // Pulse step, then count busy cycles until busy drops again.
  task automatic run_gen(output int nb, output bit done);
    bit seen;
    seen = 0; done = 0; nb = 0;
    step = 1'b1; tick(); step = 1'b0;
    for (int i = 0; i < 100 && !done; i++) begin
      tick();
      if (busy) begin nb++; seen = 1; end
      else if (seen) done = 1;
    end
  endtask

  task automatic do_restart();
    restart = 1'b1; tick(); restart = 1'b0;
    exp_gen = 0; exp_win = 1'b0; exp_lose = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int nb, acks, bsy, mems, nrise, gap, bad_gap, k;
    bit done, prev, seen;
    reset = 1'b0; restart = 1'b0; step = 1'b0; auto = 1'b0;
    load_req = 1'b0; load_addr = '0; load_data = '0;
    exp_disp = 1'b0; exp_gen = 0; exp_win = 1'b0; exp_lose = 1'b0;
    for (int b = 0; b < 2; b++)
      for (int r = 0; r < ROWS; r++) exp_mem[b][r] = '0;

    // Reset state
    #12;
    chk_all_zero("reset_outputs");
    reset = 1'b1;
    tick();

    // Blinker
    for (int r = 0; r < ROWS; r++) do_load(AW'(r), (r == 3) ? 8'h1C : 8'h00);
    run_gen(nb, done);
    `CHK("blinker_done", done, 1'b1)
    `CHK("blinker_busy_cycles", nb, 19)
    model_gen();
    `CHK("blinker_row2", ram[1][2], 8'h08)
    `CHK("blinker_row3", ram[1][3], 8'h08)
    `CHK("blinker_row4", ram[1][4], 8'h08)
    `CHK("blinker_row0", ram[1][0], 8'h00)
    chk_bank("blinker_dst", 1'b1);
    chk_bank("blinker_src", 1'b0);
    chk_flags("blinker");

    // Lose: lone cell dies
    do_restart();
    for (int r = 0; r < ROWS; r++) do_load(AW'(r), (r == 0) ? 8'h01 : 8'h00);
    run_gen(nb, done);
    `CHK("lose_busy_cycles", nb, 19)
    model_gen();
    chk_bank("lose_dst", exp_disp);
    chk_flags("lose");
    // Sticky: step and load_req get no response
    acks = 0; bsy = 0; mems = 0;
    step = 1'b1; load_req = 1'b1; load_addr = '0; load_data = 8'hFF;
    for (int i = 0; i < 20; i++) begin
      tick(); step = 1'b0;
      if (load_ack) acks++;
      if (busy) bsy++;
      if (mem_en) mems++;
    end
    load_req = 1'b0;
    `CHK("lose_ignored_acks", acks, 0)
    `CHK("lose_ignored_busy", bsy, 0)
    `CHK("lose_ignored_mem", mems, 0)
    chk_flags("lose_sticky");

    // Restart from LOSE keeps disp_bank
    do_restart();
    chk_flags("restart_lose");

    // Win: block still life with auto
    for (int r = 0; r < ROWS; r++)
      do_load(AW'(r), (r == 3 || r == 4) ? 8'h18 : 8'h00);
    auto = 1'b1;
    prev = 0; nrise = 0; gap = 0; bad_gap = 0;
    for (int i = 0; i < 200 && !win; i++) begin
      tick();
      if (busy) begin
        if (!prev) begin
          nrise++;
          if (nrise > 1 && gap != 1) bad_gap++;
        end
        gap = 0;
      end else gap++;
      prev = busy;
    end
    for (int g = 0; g < 3; g++) model_gen();
    `CHK("win_generations", nrise, 3)
    `CHK("win_idle_gap", bad_gap, 0)
    chk_flags("win");
    chk_bank("win_dst", exp_disp);
    acks = 0; mems = 0;
    step = 1'b1; load_req = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick(); step = 1'b0;
      if (load_ack) acks++;
      if (mem_en) mems++;
    end
    load_req = 1'b0; auto = 1'b0;
    `CHK("win_no_mem", mems, 0)
    `CHK("win_no_ack", acks, 0)

    // Arbitration: load_req mid-sweep, step alongside pending load_req
    do_restart();
    for (int r = 0; r < ROWS; r++) do_load(AW'(r), (r == 3) ? 8'h1C : 8'h00);
    step = 1'b1; tick(); step = 1'b0;
    seen = 0;
    for (int i = 0; i < 10 && !seen; i++) begin tick(); if (busy) seen = 1; end
    `CHK("arb_started", seen, 1'b1)
    for (int i = 0; i < 5; i++) tick();
    load_req = 1'b1; load_addr = 3'd0; load_data = 8'h07;
    acks = 0; done = 0;
    for (int i = 0; i < 40 && !done; i++) begin
      if (load_ack) acks++;
      if (!busy) done = 1;
      else tick();
    end
    `CHK("arb_sweep_done", done, 1'b1)
    `CHK("arb_no_ack_in_sweep", acks, 0)
    `CHK("arb_post_check_idle_ack", load_ack, 1'b0)
    model_gen();
    chk_bank("arb_gen1", exp_disp);
    step = 1'b1;
    tick();
    `CHK("arb_load_first", load_ack, 1'b1)
    `CHK("arb_load_not_busy", busy, 1'b0)
    load_req = 1'b0; step = 1'b0;
    exp_mem[exp_disp][0] = 8'h07;
    tick();
    `CHK("arb_idle_busy", busy, 1'b0)
    tick();
    `CHK("arb_step_latched", busy, 1'b1)
    nb = 1; done = 0;
    for (int i = 0; i < 40 && !done; i++) begin
      tick();
      if (busy) nb++; else done = 1;
    end
    `CHK("arb_gen2_busy", nb, 19)
    model_gen();
    chk_bank("arb_gen2", exp_disp);
    chk_flags("arb");

    // Restart coinciding with CHECK
    do_restart();
    step = 1'b1; tick(); step = 1'b0;
    nb = 0;
    for (int i = 0; i < 60 && nb < 19; i++) begin tick(); if (busy) nb++; end
    `CHK("rc_reach_check", nb, 19)
    restart = 1'b1; tick(); restart = 1'b0;
    model_gen();
    exp_gen = 0; exp_win = 1'b0; exp_lose = 1'b0;
    `CHK("rc_busy", busy, 1'b0)
    chk_flags("restart_at_check");
    chk_bank("rc_dst", exp_disp);

    // Reset mid-sweep during ROW_WR of row 4
    load_random();
    step = 1'b1; tick(); step = 1'b0;
    k = 0;
    for (int i = 0; i < 60 && k < 12; i++) begin tick(); if (busy) k++; end
    `CHK("rst_row4_we", mem_we, 1'b1)
    `CHK("rst_row4_addr", mem_addr, 3'd4)
    `CHK("rst_row4_bank", mem_bank, !exp_disp)
    #2 reset = 1'b0;
    #1 chk_all_zero("reset_async");
    for (int r = 0; r < 4; r++)
      `CHK($sformatf("rst_partial_r%0d", r), ram[!exp_disp][r],
           next_row(exp_disp, r))
    tick();
    chk_all_zero("reset_held");
    reset = 1'b1;
    exp_disp = 1'b0; exp_gen = 0; exp_win = 1'b0; exp_lose = 1'b0;
    load_random();
    run_gen(nb, done);
    `CHK("rst_after_busy", nb, 19)
    model_gen();
    chk_bank("rst_after_dst", exp_disp);
    chk_flags("rst_after");

    // Randomized boards, up to two generations each
    for (int t = 0; t < 4; t++) begin
      do_restart();
      load_random();
      for (int g = 0; g < 2; g++) begin
        if (!exp_lose) begin
          run_gen(nb, done);
          `CHK("rand_busy", nb, 19)
          model_gen();
          chk_bank($sformatf("rand_t%0d_g%0d", t, g), exp_disp);
          chk_flags("rand");
        end
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
